// File: rtl/i2c_slave_if.sv
// Parallel side of the I2C target: byte delivery, byte request and transfer status.
// Latency: pure wiring, no storage.
// Backpressure: none; rx_valid and tx_load are single-cycle strobes the consumer must honour.
interface i2c_slave_if;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       rw;
    logic       addressed;
    logic       busy;

    // The I2C target owns the status/strobes and consumes tx_data.
    modport slave (
        input  tx_data,
        output rx_data, rx_valid, tx_load, rw, addressed, busy
    );

    // The register file / peripheral side supplies tx_data and watches the rest.
    modport master (
        output tx_data,
        input  rx_data, rx_valid, tx_load, rw, addressed, busy
    );
endinterface

// File: rtl/i2c_slave.sv
// Single-address I2C target with oversampled SCL/SDA; optional general call via I2C_SLAVE_GENERAL_CALL_EN.
// Latency: bus conditions seen SYNC_STAGES+1 clk after the pins; SDA updates the clk after a detected SCL fall.
// Backpressure: none; no clock stretching, rx bytes and tx requests are single-cycle strobes.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    i2c_slave_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_DATA,
        ST_RX_ACK,
        ST_TX_DATA,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_t;

    state_t state_q, state_d;

    // Input synchronisers plus one history stage for edge detection.
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    // Datapath state.
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    // Second half of a two-fall ACK window (drive, then release) or
    // "master ACKed, waiting for its SCL fall" in TX_ACK.
    logic       phase_q, phase_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rw_q, rw_d;
    logic       addressed_q, addressed_d;
    logic       busy_q, busy_d;
    logic       tx_load_c;

    // Address decode on the byte that is completing this cycle.
    logic [7:0] addr_byte;
    logic       gc_hit;
    logic       addr_hit;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s &  scl_hist_q;
    assign start_det =  scl_s &  scl_hist_q &  sda_hist_q & ~sda_s;
    assign stop_det  =  scl_s &  scl_hist_q & ~sda_hist_q &  sda_s;

    assign addr_byte = {shift_q[6:0], sda_s};

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign gc_hit = (addr_byte == 8'h00);
`else
    assign gc_hit = 1'b0;
`endif

    assign addr_hit = (addr_byte[7:1] == SLAVE_ADDR) || gc_hit;

    // Open drain: only ever pull low, otherwise float.
    assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_load   = tx_load_c;
    assign bus.rw        = rw_q;
    assign bus.addressed = addressed_q;
    assign bus.busy      = busy_q;

    // Resynchronise the pins; reset to the idle-bus level so reset never fakes a condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sda};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath decode; START/STOP override whatever byte is in flight.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        sda_oe_d    = sda_oe_q;
        phase_d     = phase_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_load_c   = 1'b0;
        rw_d        = rw_q;
        addressed_d = addressed_q;
        busy_d      = busy_q;

        if (start_det) begin
            state_d     = ST_ADDR;
            cnt_d       = 3'd7;
            busy_d      = 1'b1;
            addressed_d = 1'b0;
            sda_oe_d    = 1'b0;
            phase_d     = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            cnt_d       = 3'd7;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
            sda_oe_d    = 1'b0;
            phase_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = addr_byte;
                        if (cnt_q == 3'd0) begin
                            if (addr_hit) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = gc_hit ? 1'b0 : addr_byte[0];
                                phase_d = 1'b0;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d    = 1'b1;
                            addressed_d = 1'b1;
                            phase_d     = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            cnt_d   = 3'd7;
                            if (rw_q) begin
                                // First read byte is fetched on the ACK-release fall
                                // and its MSB goes straight onto the bus.
                                state_d   = ST_TX_DATA;
                                tx_load_c = 1'b1;
                                shift_d   = bus.tx_data;
                                sda_oe_d  = ~bus.tx_data[7];
                            end else begin
                                state_d  = ST_RX_DATA;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                ST_RX_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (cnt_q == 3'd0) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                            state_d    = ST_RX_ACK;
                            phase_d    = 1'b0;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = ST_RX_DATA;
                            cnt_d    = 3'd7;
                        end
                    end
                end
                ST_TX_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_TX_ACK;
                            phase_d  = 1'b0;
                        end else begin
                            // Rotate rather than shift so the loaded byte stays recoverable.
                            shift_d  = {shift_q[6:0], shift_q[7]};
                            sda_oe_d = ~shift_q[6];
                            cnt_d    = cnt_q - 3'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (sda_s) begin
                            state_d  = ST_WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        tx_load_c = 1'b1;
                        shift_d   = bus.tx_data;
                        sda_oe_d  = ~bus.tx_data[7];
                        cnt_d     = 3'd7;
                        phase_d   = 1'b0;
                        state_d   = ST_TX_DATA;
                    end
                end
                ST_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 3'd7;
            shift_q     <= 8'h00;
            sda_oe_q    <= 1'b0;
            phase_q     <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rw_q        <= 1'b0;
            addressed_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            sda_oe_q    <= sda_oe_d;
            phase_q     <= phase_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rw_q        <= rw_d;
            addressed_q <= addressed_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, transaction-level model of expected ACKs and bytes.
// Latency: SCL quarter period is Q clk cycles, far above the target's detection latency.
// Backpressure: none; the master never waits on the target.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam logic [6:0] OWN_ADDR = 7'h50;
    localparam int         Q        = 8;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic scl_m     = 1'b1;
    logic sda_m_low = 1'b0;
    wire  sda_w;

    assign sda_w = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_slave_if bus ();

    i2c_slave #(
        .SLAVE_ADDR (OWN_ADDR),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i2c_scl(scl_m),
        .i2c_sda(sda_w),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_seen[$];
    int         tx_loads  = 0;
    int         overlap   = 0;
    int         wide      = 0;
    int         slave_low = 0;
    bit         rxv_prev  = 1'b0;
    bit         txl_prev  = 1'b0;

    logic [7:0] pay [0:3];
    int         pay_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observe strobes and target SDA activity away from the active edge.
    always @(negedge clk) begin
        if (bus.rx_valid) rx_seen.push_back(bus.rx_data);
        if (bus.tx_load) tx_loads++;
        if (bus.rx_valid && bus.tx_load) overlap++;
        if ((bus.rx_valid && rxv_prev) || (bus.tx_load && txl_prev)) wide++;
        if (sda_w == 1'b0 && !sda_m_low) slave_low++;
        rxv_prev = bus.rx_valid;
        txl_prev = bus.tx_load;
    end

    // Reference: which (address, direction) pairs the target must acknowledge.
    function automatic bit model_hit(input logic [6:0] a, input bit rd);
        return (a == OWN_ADDR) || (GC_EN && a == 7'h00 && !rd);
    endfunction

    task automatic quarter();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m_low = 1'b1; quarter();
        scl_m = 1'b0;     quarter();
    endtask

    task automatic bus_rstart();
        sda_m_low = 1'b0; quarter();
        scl_m = 1'b1;     quarter();
        sda_m_low = 1'b1; quarter();
        scl_m = 1'b0;     quarter();
    endtask

    task automatic bus_stop();
        sda_m_low = 1'b1; quarter();
        scl_m = 1'b1;     quarter();
        sda_m_low = 1'b0; quarter();
        quarter();
    endtask

    // One SCL period; val=1 releases SDA. Returns SDA seen mid-high.
    task automatic bus_bit(input bit val, output bit seen);
        sda_m_low = ~val; quarter();
        scl_m = 1'b1;     quarter();
        seen = sda_w;     quarter();
        scl_m = 1'b0;     quarter();
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv8(output logic [7:0] b);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            b[i] = s;
        end
    endtask

    task automatic run_xfer(input string tag, input logic [6:0] a, input bit rd,
                            input bit use_rstart, input bit do_stop);
        bit         hit, ack, s;
        logic [7:0] b;
        int         tl0, sl0;
        hit = model_hit(a, rd);
        rx_seen.delete();
        tl0 = tx_loads;
        sl0 = slave_low;
        if (rd) bus.tx_data = pay[0];
        if (use_rstart) bus_rstart(); else bus_start();
        check($sformatf("%s_busy", tag), bus.busy, 1);
        send_byte({a, rd}, ack);
        check($sformatf("%s_addr_ack", tag), ack, hit);
        if (hit) begin
            check($sformatf("%s_addressed", tag), bus.addressed, 1);
            check($sformatf("%s_rw", tag), bus.rw, rd);
            for (int i = 0; i < pay_n; i++) begin
                if (rd) begin
                    recv8(b);
                    check($sformatf("%s_rd%0d", tag, i), b, pay[i]);
                    if (i + 1 < pay_n) bus.tx_data = pay[i+1];
                    bus_bit(i + 1 == pay_n, s);
                    if (i + 1 == pay_n) check($sformatf("%s_released", tag), s, 1);
                end else begin
                    send_byte(pay[i], ack);
                    check($sformatf("%s_data_ack%0d", tag, i), ack, 1);
                end
            end
            check($sformatf("%s_still_addr", tag), bus.addressed, 1);
        end else begin
            check($sformatf("%s_no_drive", tag), slave_low - sl0, 0);
            check($sformatf("%s_not_addr", tag), bus.addressed, 0);
        end
        check($sformatf("%s_ntx", tag), tx_loads - tl0, (hit && rd) ? pay_n : 0);
        check($sformatf("%s_nrx", tag), rx_seen.size(), (hit && !rd) ? pay_n : 0);
        if (hit && !rd) begin
            for (int i = 0; i < pay_n; i++)
                if (i < rx_seen.size()) check($sformatf("%s_rx%0d", tag, i), rx_seen[i], pay[i]);
        end
        if (do_stop) begin
            bus_stop();
            check($sformatf("%s_busy_end", tag), bus.busy, 0);
            check($sformatf("%s_addr_end", tag), bus.addressed, 0);
            check($sformatf("%s_sda_end", tag), sda_w, 1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         s, ack, chained, stop_now, rd;
        logic [6:0] a;
        bus.tx_data = 8'h00;

        // Reset values while held in reset.
        repeat (4) @(posedge clk);
        #1;
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_tx_load", bus.tx_load, 0);
        check("rst_rw", bus.rw, 0);
        check("rst_addressed", bus.addressed, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sda", sda_w, 1);
        rst_n = 1'b1;
        quarter();

        pay[0] = 8'hA5; pay_n = 1;
        run_xfer("wr_hit", OWN_ADDR, 1'b0, 1'b0, 1'b1);

        pay[0] = 8'h77; pay_n = 1;
        run_xfer("wr_miss", 7'h51, 1'b0, 1'b0, 1'b1);

        pay[0] = 8'h3C; pay_n = 1;
        run_xfer("rd_hit", OWN_ADDR, 1'b1, 1'b0, 1'b1);

        pay[0] = 8'h01; pay[1] = 8'hFF; pay_n = 2;
        run_xfer("wr_multi", OWN_ADDR, 1'b0, 1'b0, 1'b1);

        pay[0] = 8'h96; pay[1] = 8'h69; pay_n = 2;
        run_xfer("rd_multi", OWN_ADDR, 1'b1, 1'b0, 1'b1);

        pay[0] = 8'h06; pay_n = 1;
        run_xfer("gen_call", 7'h00, 1'b0, 1'b0, 1'b1);

        // Write chained into a read through a repeated START.
        pay[0] = 8'h42; pay_n = 1;
        run_xfer("rs_wr", OWN_ADDR, 1'b0, 1'b0, 1'b0);
        pay[0] = 8'hC3; pay_n = 1;
        run_xfer("rs_rd", OWN_ADDR, 1'b1, 1'b1, 1'b1);

        // STOP after four data bits discards the partial byte.
        rx_seen.delete();
        bus_start();
        send_byte({OWN_ADDR, 1'b0}, ack);
        check("abort_addr_ack", ack, 1);
        for (int i = 0; i < 4; i++) bus_bit(i[0], s);
        bus_stop();
        check("abort_nrx", rx_seen.size(), 0);
        check("abort_busy", bus.busy, 0);

        // Reset pulse in the middle of the address byte (SCL low).
        bus_start();
        bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_rx_valid", bus.rx_valid, 0);
        check("mid_rst_rx_data", bus.rx_data, 0);
        check("mid_rst_sda", sda_w, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus_stop();
        pay[0] = 8'h5A; pay_n = 1;
        run_xfer("post_rst", OWN_ADDR, 1'b0, 1'b0, 1'b1);

        // Randomised transactions, sometimes chained through repeated START.
        chained = 1'b0;
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = OWN_ADDR;
                2:       a = 7'h00;
                default: a = 7'($urandom_range(0, 127));
            endcase
            rd = 1'($urandom_range(0, 1));
            pay_n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) pay[i] = 8'($urandom_range(0, 255));
            stop_now = (it == 15) || ($urandom_range(0, 3) != 0);
            run_xfer($sformatf("rnd%0d", it), a, rd, chained, stop_now);
            chained = ~stop_now;
        end

        check("strobe_overlap", overlap, 0);
        check("strobe_width", wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
